// File: rtl/fu_load_store_pkg.sv
// rtl/fu_load_store_pkg.sv - shared types for the load/store functional unit
package fu_load_store_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 6;
  localparam int ADDR_SIZE    = 64;

  typedef enum logic [3:0] {
    FU_OP_NOP,
    FU_OP_ADD,
    FU_OP_SUB,
    FU_OP_AND,
    FU_OP_ORR,
    FU_OP_EOR,
    FU_OP_LSL,
    FU_OP_LSR,
    FU_OP_LDUR,
    FU_OP_STUR,
    FU_OP_CBZ,
    FU_OP_B
  } fu_op_t;

  typedef enum logic [2:0] {LS_IDLE, LS_REQ, LS_WAIT, LS_RESP, LS_DRAIN} ls_state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [GPR_SIZE-1:0]  wdata;
  } mem_req_t;

  // Only 64-bit accesses exist, so any low address bit set is a misalignment.
  function automatic logic ls_op_bad(fu_op_t op, logic [2:0] addr_lo);
    return !(op == FU_OP_LDUR || op == FU_OP_STUR) || (addr_lo != 3'd0);
  endfunction

endpackage

// File: rtl/fu_load_store_if.sv
// rtl/fu_load_store_if.sv - req/gnt/rvalid data-memory bus
interface fu_load_store_if
  import fu_load_store_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = GPR_SIZE
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/fu_load_store_mem_port.sv
// rtl/fu_load_store_mem_port.sv - single-outstanding memory handshake (REQ/WAIT/DRAIN)
module fu_load_store_mem_port
  import fu_load_store_pkg::*;
(
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                launch,
  input  logic                flush,
  input  mem_req_t            req,
  fu_load_store_if.master     mem,
  output logic                busy,
  output logic                rsp_fire,
  output logic [GPR_SIZE-1:0] rsp_data
);

  ls_state_t state, state_d;

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= LS_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rsp_fire  = 1'b0;
    busy      = (state != LS_IDLE);
    rsp_data  = mem.rdata;
    mem.req   = (state == LS_REQ);
    mem.we    = (state == LS_REQ) ? req.we : 1'b0;
    mem.addr  = (state == LS_REQ) ? req.addr : '0;
    mem.wdata = (state == LS_REQ) ? req.wdata : '0;
    case (state)
      LS_IDLE: if (launch && !flush) state_d = LS_REQ;
      LS_REQ: begin
        // A granted access must still be drained on flush unless its response is already here.
        if (mem.gnt) begin
          if (mem.rvalid) begin
            state_d  = LS_IDLE;
            rsp_fire = !flush;
          end else begin
            state_d = flush ? LS_DRAIN : LS_WAIT;
          end
        end else if (flush) begin
          state_d = LS_IDLE;
        end
      end
      LS_WAIT: begin
        if (mem.rvalid) begin
          state_d  = LS_IDLE;
          rsp_fire = !flush;
        end else if (flush) begin
          state_d = LS_DRAIN;
        end
      end
      LS_DRAIN: if (mem.rvalid) state_d = LS_IDLE;
      default:  state_d = LS_IDLE;
    endcase
  end

endmodule

// File: rtl/fu_load_store.sv
// rtl/fu_load_store.sv - load/store unit: issue latch, alignment check, ROB broadcast
module fu_load_store
  import fu_load_store_pkg::*;
#(
  parameter int GPR_W     = GPR_SIZE,
  parameter int ROB_IDX_W = ROB_IDX_SIZE,
  parameter int ADDR_W    = ADDR_SIZE
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  fu_op_t               in_fu_op,
  input  logic [GPR_W-1:0]     in_val_a,
  input  logic [GPR_W-1:0]     in_val_b,
  input  logic [ROB_IDX_W-1:0] in_dst_rob_index,
  input  logic                 in_rob_is_mispred,
  output logic                 out_ready,
  fu_load_store_if.master      mem,
  output logic                 out_rob_done,
  output logic [ROB_IDX_W-1:0] out_rob_index,
  output logic [GPR_W-1:0]     out_rob_value,
  output logic                 out_rob_exc
);

  // pend marks the decode cycle between issue and either REQ or the exception response.
  logic                 pend;
  logic                 done_q;
  logic                 exc_q;
  fu_op_t               op_q;
  mem_req_t             req_q;
  logic [ROB_IDX_W-1:0] dst_q;
  logic [GPR_W-1:0]     value_q;
  logic [ADDR_W-1:0]    addr_a;
  logic                 mem_busy;
  logic                 rsp_fire;
  logic [GPR_SIZE-1:0]  rsp_data;
  logic                 accept;
  logic                 bad;
  logic                 launch;

  assign addr_a    = ADDR_W'(in_val_a);
  assign out_ready = !(pend || mem_busy || done_q);
  assign accept    = in_start && out_ready && !in_rob_is_mispred;
  assign bad       = ls_op_bad(op_q, req_q.addr[2:0]);
  assign launch    = pend && !bad && !in_rob_is_mispred;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pend    <= 1'b0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      op_q    <= FU_OP_NOP;
      req_q   <= '0;
      dst_q   <= '0;
      value_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        pend        <= 1'b1;
        op_q        <= in_fu_op;
        req_q.we    <= (in_fu_op == FU_OP_STUR);
        req_q.addr  <= ADDR_SIZE'(addr_a);
        req_q.wdata <= GPR_SIZE'(in_val_b);
        dst_q       <= in_dst_rob_index;
      end
      if (pend) begin
        pend <= 1'b0;
        if (bad && !in_rob_is_mispred) begin
          done_q  <= 1'b1;
          exc_q   <= 1'b1;
          value_q <= '0;
        end
      end
      if (rsp_fire) begin
        done_q  <= 1'b1;
        exc_q   <= 1'b0;
        value_q <= req_q.we ? '0 : GPR_W'(rsp_data);
      end
    end
  end

  // A flush in the response cycle must still suppress the broadcast.
  assign out_rob_done  = done_q && !in_rob_is_mispred;
  assign out_rob_index = dst_q;
  assign out_rob_value = value_q;
  assign out_rob_exc   = exc_q;

  fu_load_store_mem_port u_mem_port (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .launch   (launch),
    .flush    (in_rob_is_mispred),
    .req      (req_q),
    .mem      (mem),
    .busy     (mem_busy),
    .rsp_fire (rsp_fire),
    .rsp_data (rsp_data)
  );

endmodule

// File: tb/tb_fu_load_store.sv
// tb/tb_fu_load_store.sv - self-checking bench for fu_load_store
module tb_fu_load_store;
  import fu_load_store_pkg::*;

  logic        in_clk;
  logic        in_rst;
  logic        in_start;
  fu_op_t      in_fu_op;
  logic [63:0] in_val_a;
  logic [63:0] in_val_b;
  logic [5:0]  in_dst_rob_index;
  logic        in_rob_is_mispred;
  logic        out_ready;
  logic        out_rob_done;
  logic [5:0]  out_rob_index;
  logic [63:0] out_rob_value;
  logic        out_rob_exc;

  fu_load_store_if mem_bus ();

  fu_load_store dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_start          (in_start),
    .in_fu_op          (in_fu_op),
    .in_val_a          (in_val_a),
    .in_val_b          (in_val_b),
    .in_dst_rob_index  (in_dst_rob_index),
    .in_rob_is_mispred (in_rob_is_mispred),
    .out_ready         (out_ready),
    .mem               (mem_bus),
    .out_rob_done      (out_rob_done),
    .out_rob_index     (out_rob_index),
    .out_rob_value     (out_rob_value),
    .out_rob_exc       (out_rob_exc)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_done_cnt, obs_done_cyc, obs_req_cnt, obs_req_bad, obs_first_req, obs_ready_cyc;
  logic [63:0] obs_val;
  logic [5:0]  obs_idx;
  logic        obs_exc;

  int          exp_done_cnt, exp_done_cyc, exp_req_cnt, exp_ready_cyc;
  logic [63:0] exp_val;
  logic        exp_exc;

  // Drives one issue at relative cycle 0 and plays the memory; returns when out_ready comes back.
  task automatic run_op(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] dst, input int gdly, input int rdly, input logic [63:0] rd,
                        input int flush_cyc, input int rst_cyc, input bit spam);
    int req_seen = 0;
    int gnt_cyc  = -1;
    bit granted  = 0;
    obs_done_cnt = 0; obs_done_cyc = -1; obs_req_bad = 0; obs_first_req = -1; obs_ready_cyc = -1;
    obs_val = '0; obs_idx = '0; obs_exc = 1'b0;
    in_start = 1'b1; in_fu_op = op; in_val_a = a; in_val_b = b; in_dst_rob_index = dst;
    in_rob_is_mispred = (flush_cyc == 0);
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = {$urandom, $urandom};
    @(posedge in_clk); #1;
    for (int c = 1; c < 64; c++) begin
      if (out_ready) begin
        obs_ready_cyc = c;
        break;
      end
      in_rst = (c == rst_cyc);
      in_rob_is_mispred = (c == flush_cyc);
      in_start = spam;
      if (spam) begin
        in_fu_op = FU_OP_STUR;
        in_val_a = {$urandom, $urandom} & ~64'h7;
        in_val_b = {$urandom, $urandom};
        in_dst_rob_index = 6'($urandom);
      end
      mem_bus.gnt = mem_bus.req && !granted && (req_seen == gdly);
      if (mem_bus.req) begin
        req_seen++;
        if (obs_first_req < 0) obs_first_req = c;
        if (mem_bus.addr !== a || mem_bus.we !== (op == FU_OP_STUR) ||
            (op == FU_OP_STUR && mem_bus.wdata !== b)) obs_req_bad++;
      end
      if (mem_bus.gnt) begin
        granted = 1;
        gnt_cyc = c;
      end
      mem_bus.rvalid = granted && (c == gnt_cyc + rdly);
      mem_bus.rdata  = mem_bus.rvalid ? rd : {$urandom, $urandom};
      #1;
      if (out_rob_done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c; obs_val = out_rob_value; obs_idx = out_rob_index; obs_exc = out_rob_exc;
        end
      end
      @(posedge in_clk); #1;
    end
    obs_req_cnt = req_seen;
    in_start = 1'b0; in_rob_is_mispred = 1'b0; in_rst = 1'b0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
  endtask

  // Reference: cycle-level outcome derived from the documented latencies and flush rules.
  task automatic predict(input fu_op_t op, input logic [63:0] a, input int gdly, input int rdly,
                         input logic [63:0] rd, input int f);
    bit legal = (op == FU_OP_LDUR || op == FU_OP_STUR) && (a[2:0] == 3'd0);
    int g = 2 + gdly;
    int v = g + rdly;
    exp_done_cnt = 0; exp_done_cyc = -1; exp_req_cnt = 0; exp_val = '0; exp_exc = 1'b0;
    if (f == 0) begin
      exp_ready_cyc = 1;
    end else if (!legal) begin
      if (f == 1 || f == 2) exp_ready_cyc = f + 1;
      else begin
        exp_done_cnt = 1; exp_done_cyc = 2; exp_exc = 1'b1; exp_ready_cyc = 3;
      end
    end else if (f == 1) begin
      exp_ready_cyc = 2;
    end else if (f >= 2 && f < g) begin
      exp_req_cnt = f - 1; exp_ready_cyc = f + 1;
    end else begin
      exp_req_cnt = gdly + 1;
      if (f >= g && f <= v + 1) exp_ready_cyc = (f <= v) ? v + 1 : v + 2;
      else begin
        exp_done_cnt = 1; exp_done_cyc = v + 1; exp_ready_cyc = v + 2;
        exp_val = (op == FU_OP_STUR) ? 64'd0 : rd;
      end
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_start = 1'b0; in_fu_op = FU_OP_NOP; in_val_a = '0; in_val_b = '0;
    in_dst_rob_index = '0; in_rob_is_mispred = 1'b0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    repeat (3) @(posedge in_clk);
    #1; in_rst = 1'b0; #1;
    n_checks++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", out_ready); end
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_bus.req); end
    n_checks++; if (out_rob_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", out_rob_done); end
    n_checks++; if (out_rob_exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", out_rob_exc); end
    n_checks++; if (out_rob_value !== 64'd0) begin n_fail++; $display("FAIL reset_value got=%h exp=0", out_rob_value); end
    n_checks++; if (mem_bus.addr !== 64'd0 || mem_bus.wdata !== 64'd0 || mem_bus.we !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus addr=%h wdata=%h we=%b exp=0", mem_bus.addr, mem_bus.wdata, mem_bus.we);
    end
    @(posedge in_clk); #1;
  endtask

  task automatic test_load();
    run_op(FU_OP_LDUR, 64'h40, 64'h0, 6'd5, 0, 0, 64'hDEAD, -1, -1, 1'b0);
    n_checks++; if (obs_first_req !== 2) begin n_fail++; $display("FAIL load_first_req got=%0d exp=2", obs_first_req); end
    n_checks++; if (obs_done_cyc !== 3) begin n_fail++; $display("FAIL load_done_cyc got=%0d exp=3", obs_done_cyc); end
    n_checks++; if (obs_idx !== 6'd5) begin n_fail++; $display("FAIL load_index got=%0d exp=5", obs_idx); end
    n_checks++; if (obs_val !== 64'hDEAD) begin n_fail++; $display("FAIL load_value got=%h exp=dead", obs_val); end
    n_checks++; if (obs_exc !== 1'b0) begin n_fail++; $display("FAIL load_exc got=%b exp=0", obs_exc); end
  endtask

  task automatic test_store_wait();
    run_op(FU_OP_STUR, 64'h80, 64'd42, 6'd3, 3, 1, 64'h1234_5678, -1, -1, 1'b0);
    n_checks++; if (obs_req_cnt !== 4) begin n_fail++; $display("FAIL store_req_cycles got=%0d exp=4", obs_req_cnt); end
    n_checks++; if (obs_req_bad !== 0) begin n_fail++; $display("FAIL store_req_stable bad_cycles=%0d exp=0", obs_req_bad); end
    n_checks++; if (obs_done_cyc !== 7) begin n_fail++; $display("FAIL store_done_cyc got=%0d exp=7", obs_done_cyc); end
    n_checks++; if (obs_val !== 64'd0 || obs_idx !== 6'd3) begin
      n_fail++; $display("FAIL store_result value=%h index=%0d exp value=0 index=3", obs_val, obs_idx);
    end
    n_checks++; if (obs_ready_cyc !== 8) begin n_fail++; $display("FAIL store_ready_cyc got=%0d exp=8", obs_ready_cyc); end
  endtask

  task automatic test_misaligned();
    run_op(FU_OP_LDUR, 64'h43, 64'h0, 6'd9, 0, 0, 64'h55, -1, -1, 1'b0);
    n_checks++; if (obs_req_cnt !== 0) begin n_fail++; $display("FAIL misalign_req got=%0d exp=0", obs_req_cnt); end
    n_checks++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL misalign_done_cyc got=%0d exp=2", obs_done_cyc); end
    n_checks++; if (obs_exc !== 1'b1 || obs_idx !== 6'd9) begin
      n_fail++; $display("FAIL misalign_exc exc=%b index=%0d exp exc=1 index=9", obs_exc, obs_idx);
    end
    run_op(FU_OP_ADD, 64'h100, 64'h0, 6'd1, 0, 0, 64'h55, -1, -1, 1'b0);
    n_checks++; if (obs_req_cnt !== 0 || obs_exc !== 1'b1 || obs_done_cyc !== 2) begin
      n_fail++; $display("FAIL illegal_op req=%0d exc=%b done_cyc=%0d exp 0/1/2", obs_req_cnt, obs_exc, obs_done_cyc);
    end
  endtask

  task automatic test_flush_wait();
    run_op(FU_OP_LDUR, 64'h200, 64'h0, 6'd7, 0, 3, 64'hBEEF, 3, -1, 1'b0);
    n_checks++; if (obs_done_cnt !== 0) begin n_fail++; $display("FAIL flush_wait_done got=%0d exp=0", obs_done_cnt); end
    n_checks++; if (obs_ready_cyc !== 6) begin n_fail++; $display("FAIL flush_wait_ready got=%0d exp=6", obs_ready_cyc); end
  endtask

  task automatic test_flush_req_back_to_back();
    run_op(FU_OP_LDUR, 64'h300, 64'h0, 6'd2, 5, 0, 64'h77, 3, -1, 1'b0);
    n_checks++; if (obs_req_cnt !== 2) begin n_fail++; $display("FAIL flush_req_cycles got=%0d exp=2", obs_req_cnt); end
    n_checks++; if (obs_done_cnt !== 0 || obs_ready_cyc !== 4) begin
      n_fail++; $display("FAIL flush_req_idle done=%0d ready_cyc=%0d exp 0/4", obs_done_cnt, obs_ready_cyc);
    end
    run_op(FU_OP_LDUR, 64'h308, 64'h0, 6'd11, 1, 0, 64'hCAFE_F00D, -1, -1, 1'b0);
    n_checks++; if (obs_done_cyc !== 4 || obs_val !== 64'hCAFE_F00D || obs_idx !== 6'd11) begin
      n_fail++; $display("FAIL b2b_load done_cyc=%0d value=%h index=%0d exp 4/cafef00d/11", obs_done_cyc, obs_val, obs_idx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      int gd = $urandom_range(0, 3);
      int rdl = $urandom_range(0, 3);
      int f = -1;
      fu_op_t op = (r < 6) ? FU_OP_LDUR : (r < 9) ? FU_OP_STUR : fu_op_t'(4'($urandom_range(0, 7)));
      logic [63:0] a = {$urandom, $urandom} & ~64'h7;
      logic [63:0] b = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      logic [5:0] dst = 6'($urandom);
      if ($urandom_range(0, 3) == 0) a[2:0] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 2) == 0) f = $urandom_range(0, gd + rdl + 4);
      predict(op, a, gd, rdl, rd, f);
      run_op(op, a, b, dst, gd, rdl, rd, f, -1, 1'($urandom));
      n_checks++; if (obs_done_cnt !== exp_done_cnt) begin n_fail++; $display("FAIL rnd%0d_done_cnt got=%0d exp=%0d", i, obs_done_cnt, exp_done_cnt); end
      n_checks++; if (obs_done_cyc !== exp_done_cyc) begin n_fail++; $display("FAIL rnd%0d_done_cyc got=%0d exp=%0d", i, obs_done_cyc, exp_done_cyc); end
      n_checks++; if (obs_ready_cyc !== exp_ready_cyc) begin n_fail++; $display("FAIL rnd%0d_ready_cyc got=%0d exp=%0d", i, obs_ready_cyc, exp_ready_cyc); end
      n_checks++; if (obs_req_cnt !== exp_req_cnt) begin n_fail++; $display("FAIL rnd%0d_req_cnt got=%0d exp=%0d", i, obs_req_cnt, exp_req_cnt); end
      n_checks++; if (obs_req_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_req_stable bad_cycles=%0d exp=0", i, obs_req_bad); end
      if (exp_done_cnt == 1) begin
        n_checks++; if (obs_val !== exp_val || obs_exc !== exp_exc || obs_idx !== dst) begin
          n_fail++; $display("FAIL rnd%0d_result value=%h exc=%b index=%0d exp %h/%b/%0d", i, obs_val, obs_exc, obs_idx, exp_val, exp_exc, dst);
        end
      end
    end
  endtask

  task automatic test_busy_reset();
    run_op(FU_OP_LDUR, 64'h400, 64'h0, 6'd13, 0, 4, 64'h99, -1, 4, 1'b1);
    n_checks++; if (obs_done_cnt !== 0) begin n_fail++; $display("FAIL busy_reset_done got=%0d exp=0", obs_done_cnt); end
    n_checks++; if (obs_req_cnt !== 1) begin n_fail++; $display("FAIL busy_reset_req got=%0d exp=1", obs_req_cnt); end
    n_checks++; if (obs_ready_cyc !== 5) begin n_fail++; $display("FAIL busy_reset_ready got=%0d exp=5", obs_ready_cyc); end
    #1;
    n_checks++; if (out_rob_value !== 64'd0 || out_rob_index !== 6'd0 || out_rob_exc !== 1'b0 || out_rob_done !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_rob value=%h index=%0d exc=%b done=%b exp all 0", out_rob_value, out_rob_index, out_rob_exc, out_rob_done);
    end
    n_checks++; if (mem_bus.req !== 1'b0 || mem_bus.addr !== 64'd0 || out_ready !== 1'b1) begin
      n_fail++; $display("FAIL busy_reset_bus req=%b addr=%h ready=%b exp 0/0/1", mem_bus.req, mem_bus.addr, out_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_misaligned();
    test_flush_wait();
    test_flush_req_back_to_back();
    test_random();
    test_busy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
